// File: rtl/mem_arbiter.sv
// Three-way arbiter (ioctl download, video DMA, CPU) in front of a single-port byte memory.
// Accesses are sequenced IDLE->ISSUE->WAIT->DONE with a bounded-wait boost for the CPU.
module mem_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int MEM_LAT     = 2,
    parameter int CPU_MAXWAIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_din,
    output logic              dl_ack,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic [7:0]        dma_dout,
    output logic              dma_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_DMA, OWN_CPU} owner_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
    localparam logic [7:0] WAIT_MAX = 8'(CPU_MAXWAIT);

    state_t            state, state_n;
    owner_t            owner, owner_n;
    logic [3:0]        lat_cnt, lat_cnt_n;
    logic [7:0]        cpu_wait, cpu_wait_n;
    logic              is_write, is_write_n;
    logic              cpu_grant;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_din_n, dma_dout_n, cpu_dout_n;
    logic              mem_we_n, mem_rd_n, dl_ack_n, dma_ack_n, cpu_ack_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            lat_cnt  <= '0;
            cpu_wait <= '0;
            is_write <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            dl_ack   <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_dout <= '0;
            cpu_dout <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            lat_cnt  <= lat_cnt_n;
            cpu_wait <= cpu_wait_n;
            is_write <= is_write_n;
            mem_addr <= mem_addr_n;
            mem_din  <= mem_din_n;
            mem_we   <= mem_we_n;
            mem_rd   <= mem_rd_n;
            dl_ack   <= dl_ack_n;
            dma_ack  <= dma_ack_n;
            cpu_ack  <= cpu_ack_n;
            dma_dout <= dma_dout_n;
            cpu_dout <= cpu_dout_n;
        end
    end

    // Strobes and acks are computed one cycle early so every output leaves a flop.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        lat_cnt_n  = lat_cnt;
        is_write_n = is_write;
        mem_addr_n = mem_addr;
        mem_din_n  = mem_din;
        dma_dout_n = dma_dout;
        cpu_dout_n = cpu_dout;
        mem_we_n   = 1'b0;
        mem_rd_n   = 1'b0;
        dl_ack_n   = 1'b0;
        dma_ack_n  = 1'b0;
        cpu_ack_n  = 1'b0;
        cpu_grant  = 1'b0;

        case (state)
            IDLE: begin
                if (dl_req) begin
                    owner_n    = OWN_DL;
                    mem_addr_n = dl_addr;
                    mem_din_n  = dl_din;
                    is_write_n = 1'b1;
                    mem_we_n   = 1'b1;
                    state_n    = ISSUE;
                end else if (cpu_req && (cpu_wait >= WAIT_MAX)) begin
                    cpu_grant = 1'b1;
                end else if (dma_req) begin
                    owner_n    = OWN_DMA;
                    mem_addr_n = dma_addr;
                    is_write_n = 1'b0;
                    mem_rd_n   = 1'b1;
                    state_n    = ISSUE;
                end else if (cpu_req) begin
                    cpu_grant = 1'b1;
                end
                if (cpu_grant) begin
                    owner_n    = OWN_CPU;
                    mem_addr_n = cpu_addr;
                    mem_din_n  = cpu_din;
                    is_write_n = cpu_we;
                    mem_we_n   = cpu_we;
                    mem_rd_n   = !cpu_we;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_n = LAT_LOAD;
                state_n   = WAIT;
            end
            WAIT: begin
                // The last WAIT cycle is MEM_LAT cycles after the strobe: read data is valid here.
                if (lat_cnt == 4'd0) begin
                    state_n   = DONE;
                    dl_ack_n  = (owner == OWN_DL);
                    dma_ack_n = (owner == OWN_DMA);
                    cpu_ack_n = (owner == OWN_CPU);
                    if (!is_write && owner == OWN_DMA) dma_dout_n = mem_dout;
                    if (!is_write && owner == OWN_CPU) cpu_dout_n = mem_dout;
                end else begin
                    lat_cnt_n = lat_cnt - 4'd1;
                end
            end
            DONE: begin
                owner_n = OWN_NONE;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        cpu_wait_n = cpu_wait;
        if (cpu_grant)
            cpu_wait_n = '0;
        else if (cpu_req && owner != OWN_CPU && cpu_wait < WAIT_MAX)
            cpu_wait_n = cpu_wait + 8'd1;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LAT=2 instance for most scenarios, a MEM_LAT=1 instance for back-to-back DMA.
module tb_mem_arbiter;

    localparam int AW = 25;

    typedef struct { bit we; logic [AW-1:0] addr; logic [7:0] din; } strobe_t;
    typedef struct { int who; logic [7:0] dout; } ack_t;
    typedef struct { int who; bit we; logic [AW-1:0] addr; logic [7:0] din; logic [7:0] rdata; } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic dl_req, dma_req, cpu_req, cpu_we;
    logic [AW-1:0] dl_addr, dma_addr, cpu_addr;
    logic [7:0] dl_din, cpu_din;

    logic dl_ack_a, dma_ack_a, cpu_ack_a, mem_we_a, mem_rd_a;
    logic [7:0] dma_dout_a, cpu_dout_a, mem_din_a, mem_dout_a;
    logic [AW-1:0] mem_addr_a;
    logic dl_ack_b, dma_ack_b, cpu_ack_b, mem_we_b, mem_rd_b;
    logic [7:0] dma_dout_b, cpu_dout_b, mem_din_b, mem_dout_b;
    logic [AW-1:0] mem_addr_b;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .MEM_LAT(2), .CPU_MAXWAIT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack_a),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout_a), .dma_ack(dma_ack_a),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout_a), .cpu_ack(cpu_ack_a),
        .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a), .mem_rd(mem_rd_a),
        .mem_dout(mem_dout_a)
    );

    mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1), .CPU_MAXWAIT(8)) dut_lat1 (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack_b),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout_b), .dma_ack(dma_ack_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout_b), .cpu_ack(cpu_ack_b),
        .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b), .mem_rd(mem_rd_b),
        .mem_dout(mem_dout_b)
    );

    // Memory contents are a fixed function of address; read data appears MEM_LAT cycles after the address.
    function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    logic [7:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        pa0 <= mem_fn(mem_addr_a);
        pa1 <= pa0;
        pb0 <= mem_fn(mem_addr_b);
    end
    assign mem_dout_a = pa1;
    assign mem_dout_b = pb0;

    bit sel;
    logic s_we, s_rd, s_dl_ack, s_dma_ack, s_cpu_ack;
    logic [AW-1:0] s_addr;
    logic [7:0] s_din, s_dma_dout, s_cpu_dout;
    assign s_we       = sel ? mem_we_b   : mem_we_a;
    assign s_rd       = sel ? mem_rd_b   : mem_rd_a;
    assign s_addr     = sel ? mem_addr_b : mem_addr_a;
    assign s_din      = sel ? mem_din_b  : mem_din_a;
    assign s_dl_ack   = sel ? dl_ack_b   : dl_ack_a;
    assign s_dma_ack  = sel ? dma_ack_b  : dma_ack_a;
    assign s_cpu_ack  = sel ? cpu_ack_b  : cpu_ack_a;
    assign s_dma_dout = sel ? dma_dout_b : dma_dout_a;
    assign s_cpu_dout = sel ? cpu_dout_b : cpu_dout_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hold_dl, hold_dma, hold_cpu;
    logic [7:0] cpu_model;
    strobe_t sq[$];
    ack_t aq[$];
    int strobe_cyc[$];
    int ack_cyc[$];
    int ack_who[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name, input string detail);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    task automatic monitor();
        logic [2:0] ackv;
        int who;
        strobe_t s;
        ack_t a;
        check("we_rd_exclusive", 32'(s_we & s_rd), 32'd0);
        if (s_we || s_rd) begin
            strobe_cyc.push_back(cyc);
            if (sq.size() == 0) begin
                note_fail("unexpected_strobe", $sformatf("addr 0x%0h we %0b", s_addr, s_we));
            end else begin
                s = sq.pop_front();
                check("strobe_we", 32'(s_we), 32'(s.we));
                check("strobe_addr", 32'(s_addr), 32'(s.addr));
                if (s.we) check("strobe_din", 32'(s_din), 32'(s.din));
            end
        end
        ackv = {s_cpu_ack, s_dma_ack, s_dl_ack};
        if (ackv != 3'b000) begin
            who = (ackv == 3'b001) ? 0 : (ackv == 3'b010) ? 1 : (ackv == 3'b100) ? 2 : 3;
            ack_cyc.push_back(cyc);
            ack_who.push_back(who);
            if (aq.size() == 0) begin
                note_fail("unexpected_ack", $sformatf("ack bits %b", ackv));
            end else begin
                a = aq.pop_front();
                check("ack_owner", 32'(who), 32'(a.who));
                if (a.who == 1) check("dma_dout", 32'(s_dma_dout), 32'(a.dout));
                if (a.who == 2) check("cpu_dout", 32'(s_cpu_dout), 32'(a.dout));
            end
            if (ackv[0] && !hold_dl)  dl_req  = 1'b0;
            if (ackv[1] && !hold_dma) dma_req = 1'b0;
            if (ackv[2] && !hold_cpu) cpu_req = 1'b0;
        end
    endtask

    // One cycle: observe at the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_test();
        cyc = 0;
        strobe_cyc.delete();
        ack_cyc.delete();
        ack_who.delete();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while (aq.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (aq.size() != 0) begin
            note_fail("ack_timeout", $sformatf("%0d acks outstanding", aq.size()));
            aq.delete();
            sq.delete();
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        dl_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
        reset_n = 1'b0;
        sq.delete();
        aq.delete();
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic apply_stimulus(input vec_t v);
        case (v.who)
            0: begin
                dl_req = 1'b1; dl_addr = v.addr; dl_din = v.din;
                sq.push_back(strobe_t'{1'b1, v.addr, v.din});
                aq.push_back(ack_t'{0, 8'h00});
            end
            1: begin
                dma_req = 1'b1; dma_addr = v.addr;
                sq.push_back(strobe_t'{1'b0, v.addr, 8'h00});
                aq.push_back(ack_t'{1, v.rdata});
            end
            default: begin
                cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din;
                if (!v.we) cpu_model = v.rdata;
                sq.push_back(strobe_t'{v.we, v.addr, v.din});
                aq.push_back(ack_t'{2, cpu_model});
            end
        endcase
    endtask

    task automatic check_output(input string tag, input logic [AW-1:0] addr);
        check({tag, "_strobe_count"}, 32'(strobe_cyc.size()), 32'd1);
        if (strobe_cyc.size() > 0) check({tag, "_strobe_cycle"}, 32'(strobe_cyc[0]), 32'd1);
        check({tag, "_ack_count"}, 32'(ack_cyc.size()), 32'd1);
        if (ack_cyc.size() > 0) check({tag, "_ack_cycle"}, 32'(ack_cyc[0]), 32'd4);
        check({tag, "_addr_hold"}, 32'(s_addr), 32'(addr));
    endtask

    initial begin
        vecs[0] = vec_t'{2, 1'b0, 25'h00100, 8'h00, 8'h5A};
        vecs[1] = vec_t'{1, 1'b0, 25'h0004B, 8'h00, 8'h11};
        vecs[2] = vec_t'{0, 1'b1, 25'h00010, 8'hC3, 8'h00};
        vecs[3] = vec_t'{2, 1'b0, 25'h000FF, 8'h00, 8'hA5};
        vecs[4] = vec_t'{2, 1'b1, 25'h00020, 8'h00, 8'h00};
        vecs[5] = vec_t'{1, 1'b0, 25'h00078, 8'h00, 8'h22};

        sel = 1'b0;
        hold_dl = 1'b0; hold_dma = 1'b0; hold_cpu = 1'b0;
        cpu_model = 8'h00;
        reset_n = 1'b0;
        dl_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        dl_addr = '0; dma_addr = '0; cpu_addr = '0; dl_din = '0; cpu_din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_mem_rd", 32'(mem_rd_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_acks", 32'({dl_ack_a, dma_ack_a, cpu_ack_a}), 32'd0);
        check("rst_douts", 32'({dma_dout_a, cpu_dout_a}), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single accesses from the vector table");
        for (int i = 0; i < 6; i++) begin
            begin_test();
            apply_stimulus(vecs[i]);
            run_until_idle(20);
            check_output($sformatf("vec%0d", i), vecs[i].addr);
        end

        $display("[TB] download and CPU write requested together");
        begin_test();
        dl_req = 1'b1; dl_addr = 25'h00300; dl_din = 8'h77;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h00200; cpu_din = 8'h33;
        sq.push_back(strobe_t'{1'b1, 25'h00300, 8'h77});
        sq.push_back(strobe_t'{1'b1, 25'h00200, 8'h33});
        aq.push_back(ack_t'{0, 8'h00});
        aq.push_back(ack_t'{2, cpu_model});
        run_until_idle(30);
        check("dlcpu_ack_count", 32'(ack_who.size()), 32'd2);
        if (ack_who.size() == 2) begin
            check("dlcpu_first_ack", 32'(ack_who[0]), 32'd0);
            check("dlcpu_ack_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd5);
        end
        if (strobe_cyc.size() == 2) check("dlcpu_cpu_we_cycle", 32'(strobe_cyc[1]), 32'd6);
        else note_fail("dlcpu_strobes", $sformatf("%0d strobes", strobe_cyc.size()));

        $display("[TB] DMA and CPU both held: CPU wait bound");
        begin_test();
        hold_dma = 1'b1; hold_cpu = 1'b1;
        dma_req = 1'b1; dma_addr = 25'h0004B;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h000FF;
        cpu_model = 8'hA5;
        sq.push_back(strobe_t'{1'b0, 25'h0004B, 8'h00});
        sq.push_back(strobe_t'{1'b0, 25'h0004B, 8'h00});
        sq.push_back(strobe_t'{1'b0, 25'h000FF, 8'h00});
        sq.push_back(strobe_t'{1'b0, 25'h0004B, 8'h00});
        aq.push_back(ack_t'{1, 8'h11});
        aq.push_back(ack_t'{1, 8'h11});
        aq.push_back(ack_t'{2, 8'hA5});
        aq.push_back(ack_t'{1, 8'h11});
        for (int n = 0; n < 40 && strobe_cyc.size() < 4; n++) step();
        dma_req = 1'b0; cpu_req = 1'b0;
        hold_dma = 1'b0; hold_cpu = 1'b0;
        run_until_idle(20);
        check("starve_strobe_count", 32'(strobe_cyc.size()), 32'd4);
        if (strobe_cyc.size() == 4) begin
            check("starve_s1", 32'(strobe_cyc[1]), 32'd6);
            check("starve_cpu_grant", 32'(strobe_cyc[2]), 32'd11);
            check("starve_dma_resume", 32'(strobe_cyc[3]), 32'd16);
        end

        $display("[TB] reset during WAIT of a CPU write");
        begin_test();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h00040; cpu_din = 8'h99;
        sq.push_back(strobe_t'{1'b1, 25'h00040, 8'h99});
        step();
        step();
        cpu_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we_a), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("midrst_mem_din", 32'(mem_din_a), 32'd0);
        check("midrst_cpu_ack", 32'(cpu_ack_a), 32'd0);
        check("midrst_cpu_dout", 32'(cpu_dout_a), 32'd0);
        cpu_model = 8'h00;
        step();
        reset_n = 1'b1;
        ack_cyc.delete();
        repeat (8) step();
        check("midrst_no_ack", 32'(ack_cyc.size()), 32'd0);
        check("midrst_one_strobe", 32'(strobe_cyc.size()), 32'd1);
        begin_test();
        apply_stimulus(vecs[0]);
        run_until_idle(20);
        check_output("after_reset", vecs[0].addr);

        $display("[TB] MEM_LAT=1 back-to-back DMA reads");
        sel = 1'b1;
        do_reset();
        begin_test();
        hold_dma = 1'b1;
        dma_req = 1'b1; dma_addr = 25'h0004B;
        sq.push_back(strobe_t'{1'b0, 25'h0004B, 8'h00});
        sq.push_back(strobe_t'{1'b0, 25'h00078, 8'h00});
        aq.push_back(ack_t'{1, 8'h11});
        aq.push_back(ack_t'{1, 8'h22});
        step();
        dma_addr = 25'h00078;
        repeat (4) step();
        dma_req = 1'b0;
        hold_dma = 1'b0;
        run_until_idle(20);
        check("lat1_rd_count", 32'(strobe_cyc.size()), 32'd2);
        check("lat1_ack_count", 32'(ack_cyc.size()), 32'd2);
        if (ack_cyc.size() == 2) begin
            check("lat1_ack0_cycle", 32'(ack_cyc[0]), 32'd3);
            check("lat1_ack1_cycle", 32'(ack_cyc[1]), 32'd7);
        end

        check("sq_drained", 32'(sq.size()), 32'd0);
        check("aq_drained", 32'(aq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
